// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and widths for the 16x9 shift-add multiplier
package mult_pkg;

  localparam int MCAND_W = 16;
  localparam int QW      = 9;
  localparam int ACC_W   = 17;
  localparam int PROD_W  = 26;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/mult_controller_q_shift_reg.sv
// rtl/mult_controller_q_shift_reg.sv - multiplier / product-low register with load and serial right shift
module q_shift_reg #(
  parameter int QW = 9
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic          load,
  input  logic [QW-1:0] din,
  input  logic          shift,
  input  logic          sin,
  output logic [QW-1:0] q
);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift) begin
      q <= {sin, q[QW-1:1]};
    end
  end

endmodule

// File: rtl/mult_controller.sv
// rtl/mult_controller.sv - sequencer for the shift-add multiplier; drives the accumulator and owns Q
module mult_controller #(
  parameter int QW = mult_pkg::QW,
  parameter int CW = 4
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic          start,
  input  logic [QW-1:0] multiplier,
  input  logic          D_out,
  output logic          load_Acc,
  output logic          clear_Acc,
  output logic          shift_Acc,
  output logic [QW-1:0] Q,
  output logic          busy,
  output logic          done
);

  import mult_pkg::state_t;
  import mult_pkg::IDLE;
  import mult_pkg::CLEAR;
  import mult_pkg::ADD;
  import mult_pkg::SHIFT;
  import mult_pkg::DONE;

  if ((1 << CW) <= QW || QW < 2 ||
      mult_pkg::ACC_W != mult_pkg::MCAND_W + 1 ||
      mult_pkg::PROD_W != mult_pkg::ACC_W + QW) begin : g_bad_params
    $error("mult_controller: inconsistent widths");
  end

  state_t        state;
  logic [CW-1:0] cnt;
  logic          q_load;
  logic          q_shift;

  assign q_load  = (state == IDLE) && start;
  assign q_shift = (state == SHIFT);

  q_shift_reg #(.QW(QW)) u_q (
    .CLK   (CLK),
    .RST_n (RST_n),
    .load  (q_load),
    .din   (multiplier),
    .shift (q_shift),
    .sin   (D_out),
    .q     (Q)
  );

  // Outputs are registered one state ahead. On SHIFT->ADD, Q shifts at the same
  // edge, so the bit that will sit in Q[0] during ADD is the current Q[1].
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state     <= IDLE;
      cnt       <= '0;
      load_Acc  <= 1'b0;
      clear_Acc <= 1'b0;
      shift_Acc <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      load_Acc  <= 1'b0;
      clear_Acc <= 1'b0;
      shift_Acc <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= CLEAR;
            cnt       <= '0;
            clear_Acc <= 1'b1;
            busy      <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        CLEAR: begin
          state    <= ADD;
          load_Acc <= Q[0];
        end
        ADD: begin
          state     <= SHIFT;
          shift_Acc <= 1'b1;
        end
        SHIFT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(QW - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state    <= ADD;
            load_Acc <= Q[1];
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_controller.sv
// tb/tb_mult_controller.sv - self-checking bench with behavioural accumulator and product scoreboard
module tb_mult_controller;

  logic        CLK;
  logic        RST_n;
  logic        start;
  logic [8:0]  multiplier;
  logic        D_out;
  logic        load_Acc, clear_Acc, shift_Acc, busy, done;
  logic [8:0]  Q;

  logic [15:0] mcand;
  logic [16:0] acc;
  logic [25:0] sb_q[$];
  logic        busy_prev;
  int          n_checks = 0;
  int          n_fail   = 0;

  mult_controller #(.QW(9), .CW(4)) dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .start      (start),
    .multiplier (multiplier),
    .D_out      (D_out),
    .load_Acc   (load_Acc),
    .clear_Acc  (clear_Acc),
    .shift_Acc  (shift_Acc),
    .Q          (Q),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural 17-bit accumulator next to the controller
  assign D_out = acc[0];
  always @(posedge CLK or negedge RST_n) begin
    if (!RST_n)         acc <= '0;
    else if (clear_Acc) acc <= '0;
    else if (load_Acc)  acc <= acc + {1'b0, mcand};
    else if (shift_Acc) acc <= acc >> 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: expectation pushed when a run starts, popped on done
  always @(negedge CLK) begin
    if (!RST_n) begin
      busy_prev = 1'b0;
    end else begin
      if (busy && !busy_prev)
        sb_q.push_back({10'b0, mcand} * {17'b0, multiplier});
      if (done) begin
        if (sb_q.size() == 0) check("unexpected_done", 32'(done), 32'd0);
        else                  check("sb_product", 32'({acc, Q}), 32'(sb_q.pop_front()));
      end
      check("ctrl_onehot", 32'($countones({load_Acc, clear_Acc, shift_Acc}) <= 1), 32'd1);
      busy_prev = busy;
    end
  end

  task automatic run_op(input logic [15:0] mc, input logic [8:0] ml,
                        output int done_cyc, output int loads, output int shifts,
                        output int clears, output logic [8:0] load_mask);
    done_cyc = -1; loads = 0; shifts = 0; clears = 0; load_mask = '0;
    @(negedge CLK);
    mcand = mc; multiplier = ml; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (clear_Acc) clears++;
      if (shift_Acc) shifts++;
      if (load_Acc) begin
        loads++;
        if (c >= 2 && (c - 2) / 2 < 9) load_mask[(c - 2) / 2] = 1'b1;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      @(negedge CLK);
    end
    if (done_cyc < 0) check("run_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [15:0] mc;
    logic [8:0]  ml;
    logic [25:0] prod;
    int          loads;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int          dc, ld, sh, cl, ndone, busy_low;
    int          dcyc[$];
    logic [8:0]  mask;
    logic [25:0] p;

    vecs[0] = '{16'hFFFF, 9'h1FF,      26'h1FEFE01, 9};
    vecs[1] = '{16'h0003, 9'h005,      26'd15,      2};
    vecs[2] = '{16'hABCD, 9'h000,      26'd0,       0};
    vecs[3] = '{16'h1234, 9'b101010101, 26'h183F44, 5};
    vecs[4] = '{16'h0001, 9'h001,      26'd1,       1};
    vecs[5] = '{16'h8000, 9'h100,      26'h800000,  1};

    RST_n = 1'b0; start = 1'b0; multiplier = '0; mcand = '0;
    repeat (3) @(negedge CLK);
    check("reset_outputs", 32'({load_Acc, clear_Acc, shift_Acc, busy, done}), 32'd0);
    check("reset_Q", 32'(Q), 32'd0);
    RST_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].mc, vecs[i].ml, dc, ld, sh, cl, mask);
      check($sformatf("v%0d_done_cycle", i), 32'(dc), 32'd20);
      check($sformatf("v%0d_loads", i), 32'(ld), 32'(vecs[i].loads));
      check($sformatf("v%0d_shifts", i), 32'(sh), 32'd9);
      check($sformatf("v%0d_clears", i), 32'(cl), 32'd1);
      check($sformatf("v%0d_load_iters", i), 32'(mask), 32'(vecs[i].ml));
      check($sformatf("v%0d_product", i), 32'({acc, Q}), 32'(vecs[i].prod));
    end

    // Reset during the 5th SHIFT (cycle 11 of the run)
    @(negedge CLK);
    mcand = 16'h5A5A; multiplier = 9'h1FF; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (10) @(negedge CLK);
    check("mid_shift_before_reset", 32'(shift_Acc), 32'd1);
    #1 RST_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'({load_Acc, clear_Acc, shift_Acc, busy, done}), 32'd0);
    check("async_reset_Q", 32'(Q), 32'd0);
    sb_q.delete();
    ndone = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      if (done || busy) ndone++;
    end
    check("no_done_in_reset", 32'(ndone), 32'd0);
    RST_n = 1'b1;
    run_op(16'h0003, 9'h005, dc, ld, sh, cl, mask);
    check("post_reset_done_cycle", 32'(dc), 32'd20);
    check("post_reset_product", 32'({acc, Q}), 32'd15);

    // start pulses at cycles 3 and 10 are ignored
    @(negedge CLK);
    mcand = 16'h0123; multiplier = 9'h0B7; start = 1'b1;
    p = {10'b0, mcand} * {17'b0, multiplier};
    @(negedge CLK);
    start = 1'b0;
    ndone = 0; dc = -1;
    for (int c = 1; c <= 30; c++) begin
      if (done) begin ndone++; dc = c; end
      start = (c == 3 || c == 10);
      if (c == 3 || c == 10) multiplier = 9'h1FF;
      @(negedge CLK);
    end
    start = 1'b0;
    check("ignored_start_ndone", 32'(ndone), 32'd1);
    check("ignored_start_done_cycle", 32'(dc), 32'd20);
    check("ignored_start_Q", 32'(Q), 32'(p[8:0]));
    check("ignored_start_idle", 32'(busy), 32'd0);

    // start held high for 50 cycles: back-to-back runs
    @(negedge CLK);
    mcand = 16'h0F0F; multiplier = 9'h0C3; start = 1'b1;
    dcyc.delete();
    busy_low = 0;
    for (int c = 1; c <= 50; c++) begin
      @(negedge CLK);
      if (done) dcyc.push_back(c);
      if (!busy && dcyc.size() == 1) busy_low++;
    end
    start = 1'b0;
    check("held_ndone", 32'(dcyc.size()), 32'd2);
    if (dcyc.size() == 2) begin
      check("held_done_spacing", 32'(dcyc[1] - dcyc[0]), 32'd21);
      check("held_first_done", 32'(dcyc[0]), 32'd20);
    end
    check("held_busy_gap", 32'(busy_low), 32'd1);
    dc = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (done) begin dc = c; break; end
    end
    check("held_drain_done_seen", 32'(dc >= 0), 32'd1);
    @(negedge CLK);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
